// File: rtl/accum_table_wr_ctrl_if.sv
// Handshake/bus bundle for the accumulator table write-address sequencer.
// Optional feature macro: ACCUM_WR_OVERWRITE_EN adds overwrite / ovw_out.
// Signals:
//   start, submat_m, submat_n  tile launch request and tile indices
//   overwrite                  replace-instead-of-accumulate flag (macro only)
//   ready, busy, done          sequencer status; done pulses with a tile's final write
//   wr_en_out, wr_addr_out     per-column write enables and packed per-column addresses
//   ovw_out                    per-column overwrite flags (macro only)
// Modports: master drives requests (testbench/producer), slave is the sequencer.
interface accum_table_wr_ctrl_if #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_ROWS = 16,
    parameter int unsigned SYS_ARR_COLS = 16
);
    localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int unsigned ADDR_W         = $clog2(NUM_ACCUM_ROWS);
    localparam int unsigned M_W            = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
    localparam int unsigned N_W            = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);

    logic                             start;
    logic [M_W-1:0]                   submat_m;
    logic [N_W-1:0]                   submat_n;
    logic                             ready;
    logic                             busy;
    logic                             done;
    logic [SYS_ARR_COLS-1:0]          wr_en_out;
    logic [ADDR_W*SYS_ARR_COLS-1:0]   wr_addr_out;
`ifdef ACCUM_WR_OVERWRITE_EN
    logic                             overwrite;
    logic [SYS_ARR_COLS-1:0]          ovw_out;
`endif

    modport master (
        output start, submat_m, submat_n,
`ifdef ACCUM_WR_OVERWRITE_EN
        output overwrite,
        input  ovw_out,
`endif
        input  ready, busy, done, wr_en_out, wr_addr_out
    );

    modport slave (
        input  start, submat_m, submat_n,
`ifdef ACCUM_WR_OVERWRITE_EN
        input  overwrite,
        output ovw_out,
`endif
        output ready, busy, done, wr_en_out, wr_addr_out
    );
endinterface

// File: rtl/accum_table_wr_ctrl.sv
// Write-side address sequencer for the accumulator table. Emits column-0
// write enable/address for one SYS_ARR_ROWS x SYS_ARR_COLS output tile and
// skews them across columns (column c trails column 0 by c cycles), using
// the same row mapping as the read side.
// Optional feature macro: ACCUM_WR_OVERWRITE_EN (per-column overwrite flag).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    accum_table_wr_ctrl_if.slave (start/submat_m/submat_n in;
//          ready/busy/done/wr_en_out/wr_addr_out out; overwrite/ovw_out with macro)
module accum_table_wr_ctrl #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_ROWS = 16,
    parameter int unsigned SYS_ARR_COLS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    accum_table_wr_ctrl_if.slave   bus
);
    localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int unsigned ADDR_W         = $clog2(NUM_ACCUM_ROWS);
    localparam int unsigned ROW_W          = $clog2(SYS_ARR_ROWS);
    localparam int unsigned N_SH           = $clog2(MAX_OUT_ROWS);
    localparam int unsigned COLS           = SYS_ARR_COLS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_nxt;
    logic [ROW_W-1:0]         sub_row_q, sub_row_nxt;
    logic [ADDR_W-1:0]        base_q, base_nxt;
    logic [ADDR_W-1:0]        new_base_c;
    logic                     accept_c;
    logic                     last_row_c;

    logic                     ready_q, ready_nxt;
    logic                     busy_q, busy_nxt;
    logic                     done_q, done_nxt;
    logic                     col0_en_nxt;
    logic [ADDR_W-1:0]        col0_addr_nxt;
    logic [COLS-1:0]          wr_en_q;
    logic [ADDR_W*COLS-1:0]   wr_addr_q;

`ifdef ACCUM_WR_OVERWRITE_EN
    logic                     ovw_q, ovw_nxt;
    logic                     col0_ovw_nxt;
    logic [COLS-1:0]          ovw_pipe_q;
`endif

    // Tile base row in the table: column-block n, then row-block m.
    assign new_base_c = (ADDR_W'(bus.submat_n) << N_SH) + (ADDR_W'(bus.submat_m) << ROW_W);
    assign accept_c   = bus.start & ready_q;
    assign last_row_c = (sub_row_q == ROW_W'(SYS_ARR_ROWS - 1));

    // Next state, column-0 stage and registered status flags.
    always_comb begin
        state_nxt   = state_q;
        sub_row_nxt = sub_row_q;
        base_nxt    = base_q;
`ifdef ACCUM_WR_OVERWRITE_EN
        ovw_nxt     = ovw_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (!last_row_c)   sub_row_nxt = sub_row_q + ROW_W'(1);
                else if (!accept_c) state_nxt  = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave only once no earlier column still has a write queued.
                if (accept_c)                      state_nxt = ST_WRITE;
                else if (wr_en_q[COLS-2:0] == '0)  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (accept_c) begin
            sub_row_nxt = '0;
            base_nxt    = new_base_c;
`ifdef ACCUM_WR_OVERWRITE_EN
            ovw_nxt     = bus.overwrite;
`endif
        end

        col0_en_nxt   = (state_nxt == ST_WRITE);
        col0_addr_nxt = base_nxt + ADDR_W'(sub_row_nxt);
`ifdef ACCUM_WR_OVERWRITE_EN
        col0_ovw_nxt  = col0_en_nxt & ovw_nxt;
`endif

        ready_nxt = (state_nxt != ST_WRITE) || (sub_row_nxt == ROW_W'(SYS_ARR_ROWS - 1));
        busy_nxt  = (state_nxt != ST_IDLE) || col0_en_nxt || (wr_en_q[COLS-2:0] != '0);
        // Row index equals the low address bits, so the last-column final row is
        // detectable one stage early and lands in step with that write.
        done_nxt  = wr_en_q[COLS-2] & (&wr_addr_q[(COLS-2)*ADDR_W +: ROW_W]);
    end

    // State register and column skew chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sub_row_q  <= '0;
            base_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
`ifdef ACCUM_WR_OVERWRITE_EN
            ovw_q      <= 1'b0;
            ovw_pipe_q <= '0;
`endif
        end else begin
            state_q    <= state_nxt;
            sub_row_q  <= sub_row_nxt;
            base_q     <= base_nxt;
            ready_q    <= ready_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            wr_en_q    <= {wr_en_q[COLS-2:0], col0_en_nxt};
            wr_addr_q  <= {wr_addr_q[ADDR_W*(COLS-1)-1:0], col0_addr_nxt};
`ifdef ACCUM_WR_OVERWRITE_EN
            ovw_q      <= ovw_nxt;
            ovw_pipe_q <= {ovw_pipe_q[COLS-2:0], col0_ovw_nxt};
`endif
        end
    end

    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wr_en_out   = wr_en_q;
    assign bus.wr_addr_out = wr_addr_q;
`ifdef ACCUM_WR_OVERWRITE_EN
    assign bus.ovw_out     = ovw_pipe_q;
`endif
endmodule

// File: tb/tb_accum_table_wr_ctrl.sv
// Self-checking bench for accum_table_wr_ctrl: directed scenarios plus random
// tile launches, compared every cycle against a tile-list reference model.
module tb_accum_table_wr_ctrl;
    localparam int unsigned MAX_OUT_ROWS = 128;
    localparam int unsigned MAX_OUT_COLS = 128;
    localparam int unsigned R            = 16;
    localparam int unsigned C            = 16;
    localparam int unsigned AW           = $clog2(MAX_OUT_ROWS * (MAX_OUT_COLS / C));
    localparam int unsigned MW           = $clog2(MAX_OUT_ROWS / R);
    localparam int unsigned NW           = $clog2(MAX_OUT_COLS / C);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    accum_table_wr_ctrl_if #(
        .MAX_OUT_ROWS(MAX_OUT_ROWS), .MAX_OUT_COLS(MAX_OUT_COLS),
        .SYS_ARR_ROWS(R), .SYS_ARR_COLS(C)
    ) bus ();

    accum_table_wr_ctrl #(
        .MAX_OUT_ROWS(MAX_OUT_ROWS), .MAX_OUT_COLS(MAX_OUT_COLS),
        .SYS_ARR_ROWS(R), .SYS_ARR_COLS(C)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int done_seen = 0;

    // A launched tile: its acceptance cycle, base address and overwrite flag.
    typedef struct {
        int t;
        int base;
        bit ovw;
    } tile_t;
    tile_t tiles[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Not ready while column 0 is still on rows 0..R-2 of some tile.
    function automatic bit model_ready(input int k);
        foreach (tiles[i]) begin
            if (k >= tiles[i].t + 1 && k <= tiles[i].t + int'(R) - 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic [C-1:0]    e_en;
        logic [AW*C-1:0] e_addr;
        logic [AW*C-1:0] mask;
        logic            e_done;
        logic            e_busy;
`ifdef ACCUM_WR_OVERWRITE_EN
        logic [C-1:0]    e_ovw;
        e_ovw  = '0;
`endif
        e_en   = '0;
        e_addr = '0;
        mask   = '0;
        e_done = 1'b0;
        e_busy = 1'b0;
        foreach (tiles[i]) begin
            if (cyc >= tiles[i].t + 1 && cyc <= tiles[i].t + int'(R + C) - 1) e_busy = 1'b1;
            if (cyc == tiles[i].t + int'(R + C) - 1) e_done = 1'b1;
            for (int c = 0; c < int'(C); c++) begin
                int row;
                row = cyc - tiles[i].t - 1 - c;
                if (row >= 0 && row < int'(R)) begin
                    e_en[c]              = 1'b1;
                    e_addr[c*AW +: AW]   = AW'(tiles[i].base + row);
                    mask[c*AW +: AW]     = '1;
`ifdef ACCUM_WR_OVERWRITE_EN
                    e_ovw[c]             = tiles[i].ovw;
`endif
                end
            end
        end
        check_eq("wr_en_out", 256'(bus.wr_en_out), 256'(e_en));
        check_eq("wr_addr_out", 256'(bus.wr_addr_out & mask), 256'(e_addr));
        check_eq("done", 256'(bus.done), 256'(e_done));
        check_eq("busy", 256'(bus.busy), 256'(e_busy));
        check_eq("ready", 256'(bus.ready), 256'(model_ready(cyc)));
`ifdef ACCUM_WR_OVERWRITE_EN
        check_eq("ovw_out", 256'(bus.ovw_out), 256'(e_ovw));
`endif
        if (bus.done === 1'b1) done_seen++;
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, advance one clock.
    task automatic do_cycle(input bit st, input int m, input int n, input bit ovw);
        tile_t tl;
        check_outputs();
        bus.start    = st;
        bus.submat_m = MW'(m);
        bus.submat_n = NW'(n);
`ifdef ACCUM_WR_OVERWRITE_EN
        bus.overwrite = ovw;
`endif
        if (st && model_ready(cyc)) begin
            tl.t    = cyc;
            tl.base = n * int'(MAX_OUT_ROWS) + m * int'(R);
            tl.ovw  = ovw;
            tiles.push_back(tl);
        end
        @(posedge clk);
        #1;
        cyc++;
        while (tiles.size() > 0 && tiles[0].t + int'(R + C) - 1 < cyc) void'(tiles.pop_front());
    endtask

    task automatic run_idle(input int cycles);
        for (int i = 0; i < cycles; i++) do_cycle(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int base;
        int first_done;
        int d0;

        bus.start    = 1'b0;
        bus.submat_m = '0;
        bus.submat_n = '0;
`ifdef ACCUM_WR_OVERWRITE_EN
        bus.overwrite = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // Idle after reset: no writes, not busy, ready.
        run_idle(50);

        // Single tile m=2, n=3.
        base       = cyc;
        first_done = -1;
        d0         = done_seen;
        do_cycle(1'b1, 2, 3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (cyc - base == 1)  check_eq("col0_first_addr", 256'(bus.wr_addr_out[0 +: AW]), 256'(416));
            if (cyc - base == 16) check_eq("col15_first_addr", 256'(bus.wr_addr_out[(C-1)*AW +: AW]), 256'(416));
            if (bus.done === 1'b1 && first_done < 0) first_done = cyc - base;
            do_cycle(1'b0, 0, 0, 1'b0);
        end
        check_eq("single_done_cycle", 256'(first_done), 256'(31));
        check_eq("single_done_count", 256'(done_seen - d0), 256'(1));

        // Back-to-back tiles (0,0) then (7,7) with no gap.
        d0 = done_seen;
        do_cycle(1'b1, 0, 0, 1'b0);
        run_idle(15);
        do_cycle(1'b1, 7, 7, 1'b0);
        run_idle(40);
        check_eq("b2b_done_count", 256'(done_seen - d0), 256'(2));

        // Start held while not ready is ignored.
        d0 = done_seen;
        do_cycle(1'b1, 1, 1, 1'b0);
        for (int i = 0; i < 15; i++) do_cycle(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
        run_idle(40);
        check_eq("held_start_done_count", 256'(done_seen - d0), 256'(1));

        // Reset in the middle of a tile.
        d0 = done_seen;
        do_cycle(1'b1, 4, 5, 1'b1);
        run_idle(7);
        reset = 1'b1;
        #1;
        check_eq("rst_wr_en", 256'(bus.wr_en_out), 256'(0));
        check_eq("rst_done", 256'(bus.done), 256'(0));
        check_eq("rst_busy", 256'(bus.busy), 256'(0));
        tiles.delete();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        run_idle(40);
        check_eq("rst_done_count", 256'(done_seen - d0), 256'(0));

        // Overwrite set, then clear.
        do_cycle(1'b1, 3, 3, 1'b1);
        run_idle(40);
        do_cycle(1'b1, 3, 3, 1'b0);
        run_idle(40);

        // Random launches, including overlapped tiles and ignored starts.
        for (int i = 0; i < 3000; i++) begin
            do_cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        run_idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
